// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: debug controller states, debug word width,
// inter-stage latch widths and control-field widths.
package mips_pkg;

  typedef enum logic [1:0] {
    DBG_IDLE = 2'd0,
    DBG_RUN  = 2'd1,
    DBG_STEP = 2'd2,
    DBG_DONE = 2'd3
  } dbg_state_e;

  localparam int LEN         = 32;
  localparam int NB_PC       = 32;
  localparam int NB_INSTR    = 32;
  localparam int NB_DATA     = 32;
  localparam int NB_REG_ADDR = 5;

  localparam int NB_CTRL_EX  = 8;
  localparam int NB_CTRL_MEM = 4;
  localparam int NB_CTRL_WB  = 2;

  // Payload of each latch; every one fits in the 192-bit chain slot.
  localparam int NB_IF_ID   = NB_PC + NB_INSTR;
  localparam int NB_ID_EX   = NB_PC + 3*NB_DATA + 3*NB_REG_ADDR
                              + NB_CTRL_EX + NB_CTRL_MEM + NB_CTRL_WB;
  localparam int NB_EX_MEM  = NB_PC + 2*NB_DATA + NB_REG_ADDR + NB_CTRL_MEM + NB_CTRL_WB;
  localparam int NB_MEM_WB  = 2*NB_DATA + NB_REG_ADDR + NB_CTRL_WB;

endpackage

// File: rtl/pipe_latch_stage.sv
// One inter-stage latch with its valid bit; priority flush > hold > bubble > load,
// and nothing changes unless the pipeline is enabled this cycle.
module pipe_latch_stage #(
  parameter int NB = 192
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_flush,
  input  logic          i_hold,
  input  logic          i_bubble,
  input  logic          i_valid_in,
  input  logic [NB-1:0] i_d,
  output logic [NB-1:0] o_q,
  output logic          o_valid
);

  logic [NB-1:0] r_q;
  logic          r_valid;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (i_en) begin
      if (i_flush) begin
        r_q     <= '0;
        r_valid <= 1'b0;
      end else if (i_hold) begin
        r_q     <= r_q;
        r_valid <= r_valid;
      end else if (i_bubble) begin
        r_q     <= '0;
        r_valid <= 1'b0;
      end else begin
        r_q     <= i_d;
        r_valid <= i_valid_in;
      end
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;

endmodule

// File: rtl/pipe_latch_chain.sv
// Bank of pipeline latches with stall chain, bubble insertion, run/step/halt
// debug controller, run-cycle counter and registered word readout.
module pipe_latch_chain #(
  parameter  int N_STAGES = 4,
  parameter  int NB_STAGE = 192,
  parameter  int LEN      = 32,
  parameter  int NB_CYCLE = 32,
  localparam int N_WORDS  = (N_STAGES*NB_STAGE + LEN - 1) / LEN,
  localparam int NB_SEL   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_STAGES*NB_STAGE-1:0] i_stage_d,
  input  logic [N_STAGES-1:0]          i_stall,
  input  logic [N_STAGES-1:0]          i_flush,
  input  logic                         i_dbg_mode,
  input  logic                         i_step,
  input  logic                         i_halt_req,
  input  logic [NB_SEL-1:0]            i_dbg_sel,
  output logic [N_STAGES*NB_STAGE-1:0] o_stage_q,
  output logic [N_STAGES-1:0]          o_valid,
  output logic                         o_run_en,
  output logic                         o_halted,
  output logic [NB_CYCLE-1:0]          o_cycle_cnt,
  output logic [LEN-1:0]               o_dbg_word
);

  import mips_pkg::*;

  localparam int NB_ALL  = N_STAGES*NB_STAGE;
  localparam int N_SLOTS = 2**NB_SEL;

  dbg_state_e            r_state;
  dbg_state_e            w_state_next;
  logic                  r_step_d;
  logic                  w_step_rise;
  logic                  w_run_en;
  logic                  w_halted;
  logic [N_STAGES-1:0]   w_stall_eff;
  logic [N_STAGES-1:0]   w_bubble;
  logic [N_STAGES-1:0]   w_valid_in;
  logic [N_STAGES-1:0]   w_valid;
  logic [NB_ALL-1:0]     w_q;
  logic [NB_CYCLE-1:0]   r_cycle_cnt;
  logic [LEN-1:0]        r_dbg_word;
  logic [N_WORDS*LEN-1:0] w_flat;
  logic [LEN-1:0]        w_words [N_SLOTS];

  // A latch is frozen if it or any latch downstream of it is stalled.
  always_comb begin
    w_stall_eff = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      w_stall_eff[k] = |(i_stall >> k);
    end
  end

  always_comb begin
    w_bubble = '0;
    for (int k = 1; k < N_STAGES; k++) begin
      w_bubble[k] = w_stall_eff[k-1] & ~w_stall_eff[k];
    end
  end

  assign w_valid_in = {w_valid[N_STAGES-2:0], 1'b1};

  for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
    pipe_latch_stage #(
      .NB (NB_STAGE)
    ) u_stage (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (w_run_en),
      .i_flush    (i_flush[g]),
      .i_hold     (w_stall_eff[g]),
      .i_bubble   (w_bubble[g]),
      .i_valid_in (w_valid_in[g]),
      .i_d        (i_stage_d[g*NB_STAGE +: NB_STAGE]),
      .o_q        (w_q[g*NB_STAGE +: NB_STAGE]),
      .o_valid    (w_valid[g])
    );
  end

  assign w_step_rise = i_step & ~r_step_d;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= DBG_IDLE;
      r_step_d <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_step_d <= i_step;
    end
  end

  // STEP always lasts exactly one cycle, so a rise seen there is simply dropped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DBG_IDLE: begin
        if (i_halt_req)                    w_state_next = DBG_DONE;
        else if (!i_dbg_mode)              w_state_next = DBG_RUN;
        else if (w_step_rise)              w_state_next = DBG_STEP;
      end
      DBG_RUN: begin
        if (i_halt_req)                    w_state_next = DBG_DONE;
        else if (i_dbg_mode)               w_state_next = DBG_IDLE;
      end
      DBG_STEP: begin
        if (i_halt_req)                    w_state_next = DBG_DONE;
        else if (!i_dbg_mode)              w_state_next = DBG_RUN;
        else                               w_state_next = DBG_IDLE;
      end
      DBG_DONE:                            w_state_next = DBG_DONE;
      default:                             w_state_next = DBG_IDLE;
    endcase
  end

  always_comb begin
    w_run_en = 1'b0;
    w_halted = 1'b0;
    case (r_state)
      DBG_RUN,
      DBG_STEP: w_run_en = 1'b1;
      DBG_DONE: w_halted = 1'b1;
      default:  w_run_en = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cycle_cnt <= '0;
    end else if (w_run_en) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  always_comb begin
    w_flat             = '0;
    w_flat[NB_ALL-1:0] = w_q;
  end

  // Index slots beyond the last real word read as zero.
  for (genvar j = 0; j < N_SLOTS; j++) begin : g_word
    if (j < N_WORDS) begin : g_real
      assign w_words[j] = w_flat[j*LEN +: LEN];
    end else begin : g_pad
      assign w_words[j] = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_dbg_word <= '0;
    end else begin
      r_dbg_word <= w_words[i_dbg_sel];
    end
  end

  assign o_stage_q   = w_q;
  assign o_valid     = w_valid;
  assign o_run_en    = w_run_en;
  assign o_halted    = w_halted;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_dbg_word  = r_dbg_word;

endmodule
